// File: rtl/vector_pkg.sv
// Shared types and memory-word field positions for the multi-object vector sequencer.
package vector_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SELECT   = 4'd1,
        ST_FETCH    = 4'd2,
        ST_WAITRD   = 4'd3,
        ST_DECODE   = 4'd4,
        ST_ISSUE    = 4'd5,
        ST_WAITDONE = 4'd6,
        ST_NEXT     = 4'd7,
        ST_FINISH   = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_MOVE = 2'b01,
        OP_DRAW = 2'b10,
        OP_END  = 2'b11
    } opcode_t;

    // Word layout from the LSB up: {line,pos} opcode, then y, then x.
    localparam int OP_LSB = 0;
    localparam int OP_W   = 2;
    localparam int Y_LSB  = 2;

endpackage

// File: rtl/vector_obj_select.sv
// Finds the lowest-index object that is enabled and not yet finished this frame.
module vector_obj_select
    import vector_pkg::*;
#(
    parameter int NUM_OBJ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_OBJ-1:0] pending,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Scan downwards so the lowest pending index is the last one written.
    always_comb begin
        found = |pending;
        idx   = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            idx = pending[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/vector_sequencer.sv
// Walks up to NUM_OBJ vector lists, offsets each point per object and hands
// DRAW segments to the line drawer over a go/busy/done handshake.
module vector_sequencer
    import vector_pkg::*;
#(
    parameter int COORD_W = 8,
    parameter int ADR_W   = 10,
    parameter int DATA_W  = 2*COORD_W+2,
    parameter int NUM_OBJ = 4,
    parameter int RD_LAT  = 1,
    parameter int MAX_LEN = 256,
    parameter int BRES_W  = COORD_W+2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_OBJ-1:0]           obj_en,
    input  logic [NUM_OBJ*ADR_W-1:0]     obj_base,
    input  logic [NUM_OBJ*(COORD_W+1)-1:0] obj_dx,
    input  logic [NUM_OBJ*(COORD_W+1)-1:0] obj_dy,
    output logic [ADR_W-1:0]             mem_adr,
    output logic                         mem_rd,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         busy,
    input  logic                         done,
    output logic                         go,
    output logic [BRES_W-1:0]            stax,
    output logic [BRES_W-1:0]            stay,
    output logic [BRES_W-1:0]            endx,
    output logic [BRES_W-1:0]            endy,
    output logic                         vector_reset,
    output logic                         frame_busy,
    output logic                         frame_done,
    output logic                         len_err
);

    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int OFS_W = COORD_W + 1;
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int X_LSB = Y_LSB + COORD_W;

    state_t              state_r, state_s;
    logic [NUM_OBJ-1:0]  obj_en_r, obj_done_r;
    logic [IDX_W-1:0]    cur_idx_r, sel_idx_s;
    logic                sel_found_s;
    logic [ADR_W-1:0]    sel_base_s;
    logic [OFS_W-1:0]    sel_dx_s, sel_dy_s, dx_r, dy_r;
    logic [BRES_W-1:0]   prev_x_r, prev_y_r, new_x_s, new_y_s;
    logic [CNT_W-1:0]    word_cnt_r, cnt_inc_s;
    logic [LAT_W-1:0]    lat_cnt_r;
    logic [DATA_W-1:0]   data_r;
    opcode_t             op_s;
    logic                lat_last_s, len_hit_s;

    // Unsigned coordinate plus signed offset, no clamping.
    function automatic logic [BRES_W-1:0] add_ofs(input logic [COORD_W-1:0] c,
                                                  input logic [OFS_W-1:0] o);
        return {{(BRES_W-COORD_W){1'b0}}, c} + {{(BRES_W-OFS_W){o[OFS_W-1]}}, o};
    endfunction

    vector_obj_select #(
        .NUM_OBJ (NUM_OBJ),
        .IDX_W   (IDX_W)
    ) u_select (
        .pending (obj_en_r & ~obj_done_r),
        .found   (sel_found_s),
        .idx     (sel_idx_s)
    );

    assign sel_base_s = obj_base[int'(sel_idx_s)*ADR_W +: ADR_W];
    assign sel_dx_s   = obj_dx[int'(sel_idx_s)*OFS_W +: OFS_W];
    assign sel_dy_s   = obj_dy[int'(sel_idx_s)*OFS_W +: OFS_W];
    assign op_s       = opcode_t'(data_r[OP_LSB +: OP_W]);
    assign new_x_s    = add_ofs(data_r[X_LSB +: COORD_W], dx_r);
    assign new_y_s    = add_ofs(data_r[Y_LSB +: COORD_W], dy_r);
    assign lat_last_s = (lat_cnt_r == LAT_W'(RD_LAT - 1));
    assign cnt_inc_s  = word_cnt_r + CNT_W'(1);
    assign len_hit_s  = (cnt_inc_s == CNT_W'(MAX_LEN));

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:     state_s = start ? ST_SELECT : ST_IDLE;
            ST_SELECT:   state_s = sel_found_s ? ST_FETCH : ST_FINISH;
            ST_FETCH:    state_s = ST_WAITRD;
            ST_WAITRD:   state_s = lat_last_s ? ST_DECODE : ST_WAITRD;
            ST_DECODE: begin
                case (op_s)
                    OP_DRAW: state_s = ST_ISSUE;
                    OP_END:  state_s = ST_SELECT;
                    default: state_s = ST_NEXT;
                endcase
            end
            ST_ISSUE:    state_s = busy ? ST_ISSUE : ST_WAITDONE;
            ST_WAITDONE: state_s = done ? ST_NEXT : ST_WAITDONE;
            ST_NEXT:     state_s = len_hit_s ? ST_SELECT : ST_FETCH;
            ST_FINISH:   state_s = ST_IDLE;
            default:     state_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            obj_en_r     <= '0;
            obj_done_r   <= '0;
            cur_idx_r    <= '0;
            dx_r         <= '0;
            dy_r         <= '0;
            prev_x_r     <= '0;
            prev_y_r     <= '0;
            word_cnt_r   <= '0;
            lat_cnt_r    <= '0;
            data_r       <= '0;
            mem_adr      <= '0;
            mem_rd       <= 1'b0;
            go           <= 1'b0;
            stax         <= '0;
            stay         <= '0;
            endx         <= '0;
            endy         <= '0;
            vector_reset <= 1'b0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            state_r      <= state_s;
            mem_rd       <= (state_s == ST_FETCH);
            go           <= (state_r == ST_ISSUE) && !busy;
            vector_reset <= (state_r == ST_IDLE) && start;
            frame_busy   <= (state_s != ST_IDLE);
            frame_done   <= (state_s == ST_FINISH);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        obj_en_r   <= obj_en;
                        obj_done_r <= '0;
                        len_err    <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    if (sel_found_s) begin
                        cur_idx_r  <= sel_idx_s;
                        mem_adr    <= sel_base_s;
                        dx_r       <= sel_dx_s;
                        dy_r       <= sel_dy_s;
                        prev_x_r   <= '0;
                        prev_y_r   <= '0;
                        word_cnt_r <= '0;
                    end
                end
                ST_FETCH: lat_cnt_r <= '0;
                ST_WAITRD: begin
                    lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    if (lat_last_s) begin
                        data_r <= data_in;
                    end
                end
                ST_DECODE: begin
                    case (op_s)
                        OP_MOVE: begin
                            prev_x_r <= new_x_s;
                            prev_y_r <= new_y_s;
                        end
                        OP_DRAW: begin
                            stax     <= prev_x_r;
                            stay     <= prev_y_r;
                            endx     <= new_x_s;
                            endy     <= new_y_s;
                            prev_x_r <= new_x_s;
                            prev_y_r <= new_y_s;
                        end
                        OP_END:  obj_done_r[cur_idx_r] <= 1'b1;
                        default: ;
                    endcase
                end
                ST_NEXT: begin
                    // Runaway list without END: give up on this object.
                    mem_adr    <= mem_adr + ADR_W'(1);
                    word_cnt_r <= cnt_inc_s;
                    if (len_hit_s) begin
                        len_err                <= 1'b1;
                        obj_done_r[cur_idx_r]  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Multi-object successor to the single-list vector fetcher. It walks up to NUM_OBJ vector lists in the vector memory and translates each point by a per-object signed offset. It emits line segments to the bresenham line drawer using a go/busy/done handshake. It sits between the vector ROM/RAM and the line drawer in the vector display path, and is started once per frame by the frame controller.

## Interface
Parameters:
- COORD_W, 8, unsigned coordinate width in a memory word
- ADR_W, 10, vector memory address width
- DATA_W, 2*COORD_W+2, memory word width: x[DATA_W-1 -: COORD_W], y next COORD_W bits, line = bit 1, pos = bit 0
- NUM_OBJ, 4, number of object lists
- RD_LAT, 1, memory read latency in cycles (≥1)
- MAX_LEN, 256, word limit per object before forced termination
- BRES_W, COORD_W+2, signed output coordinate width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  frame start request, sampled only in IDLE
- obj_en  in  NUM_OBJ  per-object enable, sampled on the accepted start
- obj_base  in  NUM_OBJ*ADR_W  per-object first word address, packed with object 0 at the LSBs
- obj_dx, obj_dy  in  NUM_OBJ*(COORD_W+1)  per-object signed offset, packed
- mem_adr  out  ADR_W  memory address
- mem_rd  out  1  one-cycle read strobe
- data_in  in  DATA_W  memory read data
- busy, done  in  1  drawer busy level; drawer one-cycle completion pulse
- go  out  1  one-cycle segment start
- stax, stay, endx, endy  out  BRES_W signed  segment endpoints
- vector_reset  out  1  one-cycle drawer/frame clear
- frame_busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- len_err  out  1  sticky; set on a MAX_LEN overflow; cleared by rst or by an accepted start

## Operation
- Opcode {line,pos}:
  - 01 MOVE: set prev = (x+dx, y+dy); no segment.
  - 10 DRAW: emit segment prev→new, then set prev = new.
  - 11 END: object finished.
  - 00 NOP: skip the word.
- Point arithmetic: zero-extend x to BRES_W, sign-extend dx to BRES_W, then add. No clamping; off-screen handling belongs to the drawer.
- prev is cleared to (0,0) at each object start. A DRAW before any MOVE starts from (0,0)+offset... more precisely, from the cleared prev value (0,0).
- States:
  - IDLE: start=1 → SELECT; vector_reset=1 in the first SELECT cycle; obj_en latched.
  - SELECT: lowest-index enabled, not-yet-done object → load mem_adr=base, latch dx/dy, clear prev and word counter → FETCH. No object left → FINISH.
  - FETCH: mem_rd=1 for one cycle → WAITRD.
  - WAITRD: wait RD_LAT cycles, capture data_in → DECODE.
  - DECODE:
    - MOVE/NOP → NEXT.
    - DRAW → ISSUE.
    - END → mark the object done → SELECT.
  - ISSUE: wait for busy=0, then go=1 for one cycle with endpoints stable → WAITDONE.
  - WAITDONE: done=1 → NEXT.
  - NEXT: mem_adr+1, modulo 2^ADR_W (wraps from all-ones to 0). Word counter+1. Counter reaching MAX_LEN → set len_err, mark object done → SELECT. Otherwise → FETCH.
  - FINISH: frame_done=1 → IDLE.
- start outside IDLE is ignored.
- obj_en all zero: vector_reset, then frame_done, with no reads issued.
- done arriving outside WAITDONE is ignored.
- Endpoints hold their values from go until the next DRAW is decoded.

## Timing
- Reset values: all outputs 0, state IDLE, prev 0, mem_adr 0.
- rst mid-frame aborts the frame. No go or frame_done is issued after reset.
- start accepted at edge t:
  - vector_reset high in cycle t+1 (SELECT)
  - mem_rd in cycle t+2
  - data captured RD_LAT cycles after mem_rd
- Per DRAW word, idle drawer: FETCH, RD_LAT, DECODE, ISSUE(go), then WAITDONE until done, then NEXT.
- Per MOVE/NOP word: 3+RD_LAT cycles.
- go is never asserted while busy=1.
- go is never asserted twice without an intervening done.

## Structure
- Package vector_pkg holds:
  - state_t enum
  - opcode enum: OP_NOP, OP_MOVE, OP_DRAW, OP_END
  - field-slice localparams for the memory word
- Sub-module vector_obj_select: combinational lowest-index finder over (obj_en_latched & ~obj_done). Outputs a found flag and an index.

## Test plan
- Single object at base 0, offset 0: MOVE(10,20), DRAW(50,20), END. Expect one go with (10,20)→(50,20), then frame_done.
- Object 1 only, base 0x40, dx=-5, dy=+3: MOVE(2,0), DRAW(2,10), END. Expect endpoints (-3,3)→(-3,13), signed, and reads starting at mem_adr 0x40.
- Objects 0 and 2 enabled, object 1 disabled: expect segments in order 0 then 2, no reads from base1, and one frame_done.
- Drawer holds busy=1 for 7 cycles after DECODE of a DRAW: go is delayed until busy=0. A done pulse injected in FETCH is ignored.
- List without END, MAX_LEN=4, base=2^ADR_W-2: mem_adr wraps from 3FF to 0, len_err=1 after 4 words, frame completes.
- rst asserted during WAITDONE: all outputs 0 next cycle. A new start then runs a clean frame with len_err cleared.
